// File: rtl/seg7_scroll_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scroll_pkg
// Shared definitions for the scrolling seven-segment text driver:
//   - glyph codes stored in the message RAM (digits 0..9, letters 10..30,
//     blank 31)
//   - segment bit positions inside the {g,f,e,d,c,b,a} output vector
//   - SEG_BLANK pattern and the glyph -> segment lookup function used by
//     the seg7_glyph decoder
// -----------------------------------------------------------------------------
package seg7_scroll_pkg;

  // Glyph code width used by the lookup table (the RAM width may differ).
  localparam int GLYPH_W = 5;

  // Numeric glyphs map straight to their value.
  localparam logic [4:0] GLYPH_0 = 5'd0;
  localparam logic [4:0] GLYPH_1 = 5'd1;
  localparam logic [4:0] GLYPH_2 = 5'd2;
  localparam logic [4:0] GLYPH_3 = 5'd3;
  localparam logic [4:0] GLYPH_4 = 5'd4;
  localparam logic [4:0] GLYPH_5 = 5'd5;
  localparam logic [4:0] GLYPH_6 = 5'd6;
  localparam logic [4:0] GLYPH_7 = 5'd7;
  localparam logic [4:0] GLYPH_8 = 5'd8;
  localparam logic [4:0] GLYPH_9 = 5'd9;

  // Letters that are legible on a seven-segment digit.
  localparam logic [4:0] GLYPH_A  = 5'd10;
  localparam logic [4:0] GLYPH_B  = 5'd11;
  localparam logic [4:0] GLYPH_C  = 5'd12;
  localparam logic [4:0] GLYPH_D  = 5'd13;
  localparam logic [4:0] GLYPH_E  = 5'd14;
  localparam logic [4:0] GLYPH_F  = 5'd15;
  localparam logic [4:0] GLYPH_G  = 5'd16;
  localparam logic [4:0] GLYPH_H  = 5'd17;
  localparam logic [4:0] GLYPH_I  = 5'd18;
  localparam logic [4:0] GLYPH_J  = 5'd19;
  localparam logic [4:0] GLYPH_L  = 5'd20;
  localparam logic [4:0] GLYPH_N  = 5'd21;
  localparam logic [4:0] GLYPH_O  = 5'd22;
  localparam logic [4:0] GLYPH_P  = 5'd23;
  localparam logic [4:0] GLYPH_Q  = 5'd24;
  localparam logic [4:0] GLYPH_R  = 5'd25;
  localparam logic [4:0] GLYPH_S  = 5'd26;
  localparam logic [4:0] GLYPH_T  = 5'd27;
  localparam logic [4:0] GLYPH_U  = 5'd28;
  localparam logic [4:0] GLYPH_UL = 5'd29;
  localparam logic [4:0] GLYPH_Y  = 5'd30;
  localparam logic [4:0] GLYPH_BLANK = 5'd31;

  // Segment bit positions within the 7-bit segment vector.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Glyph code -> active-high {g,f,e,d,c,b,a} pattern. Anything not listed,
  // including GLYPH_BLANK, lights nothing.
  function automatic logic [6:0] glyphToSeg(input logic [4:0] code);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (code)
      GLYPH_0:  seg = 7'h3F;
      GLYPH_1:  seg = 7'h06;
      GLYPH_2:  seg = 7'h5B;
      GLYPH_3:  seg = 7'h4F;
      GLYPH_4:  seg = 7'h66;
      GLYPH_5:  seg = 7'h6D;
      GLYPH_6:  seg = 7'h7D;
      GLYPH_7:  seg = 7'h07;
      GLYPH_8:  seg = 7'h7F;
      GLYPH_9:  seg = 7'h6F;
      GLYPH_A:  seg = 7'h77;
      GLYPH_B:  seg = 7'h7C;
      GLYPH_C:  seg = 7'h39;
      GLYPH_D:  seg = 7'h5E;
      GLYPH_E:  seg = 7'h79;
      GLYPH_F:  seg = 7'h71;
      GLYPH_G:  seg = 7'h3D;
      GLYPH_H:  seg = 7'h76;
      GLYPH_I:  seg = 7'h30;
      GLYPH_J:  seg = 7'h1E;
      GLYPH_L:  seg = 7'h38;
      GLYPH_N:  seg = 7'h54;
      GLYPH_O:  seg = 7'h5C;
      GLYPH_P:  seg = 7'h73;
      GLYPH_Q:  seg = 7'h67;
      GLYPH_R:  seg = 7'h50;
      GLYPH_S:  seg = 7'h6D;
      GLYPH_T:  seg = 7'h78;
      GLYPH_U:  seg = 7'h3E;
      GLYPH_UL: seg = 7'h1C;
      GLYPH_Y:  seg = 7'h6E;
      default:  seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scroll_mux_glyph.sv
// -----------------------------------------------------------------------------
// seg7_glyph
// Combinational glyph decoder: CHAR_W-bit glyph code -> 7-bit segment pattern.
// Codes outside the 5-bit glyph table decode to SEG_BLANK.
// Ports:
//   i_code      [CHAR_W-1:0]  glyph code
//   o_segments  [6:0]         {g,f,e,d,c,b,a}, active high
// -----------------------------------------------------------------------------
module seg7_glyph
  import seg7_scroll_pkg::*;
#(
  parameter int CHAR_W = 5
) (
  input  logic [CHAR_W-1:0] i_code,
  output logic [6:0]        o_segments
);

  logic [GLYPH_W-1:0] w_code5;
  logic               w_outOfRange;

  // Fit the stored code onto the 5-bit table: wider codes with any upper bit
  // set cannot be a known glyph, narrower codes are zero-extended.
  generate
    if (CHAR_W > GLYPH_W) begin : g_wide
      assign w_code5      = i_code[GLYPH_W-1:0];
      assign w_outOfRange = |i_code[CHAR_W-1:GLYPH_W];
    end else if (CHAR_W == GLYPH_W) begin : g_exact
      assign w_code5      = i_code;
      assign w_outOfRange = 1'b0;
    end else begin : g_narrow
      assign w_code5      = {{(GLYPH_W-CHAR_W){1'b0}}, i_code};
      assign w_outOfRange = 1'b0;
    end
  endgenerate

  // Table lookup; out-of-range codes stay dark.
  always_comb begin
    o_segments = SEG_BLANK;
    if (!w_outOfRange) begin
      o_segments = glyphToSeg(w_code5);
    end
  end

endmodule

// File: rtl/seg7_scroll_mux.sv
// -----------------------------------------------------------------------------
// seg7_scroll_mux
// Multiplexes NUM_DIGITS common-cathode seven-segment digits and scrolls a
// runtime-loaded message of up to MSG_DEPTH glyphs, one position per step
// tick. Digit d shows RAM[(scroll_pos + d) mod msg_len] while d < msg_len,
// otherwise it stays dark.
//
// Optional feature macro: SEG7_SCROLL_BLINK_EN
//   When defined, adds input i_blink and a phase flop that toggles on each
//   step tick; segments are forced dark while i_blink && phase.
//
// Ports (AW = $clog2(MSG_DEPTH)):
//   i_clk         clock
//   i_rst_n       asynchronous active-low reset
//   i_ena         design enable; low blanks outputs and freezes all counters
//   i_wr_en       message RAM write strobe
//   i_wr_addr     [AW-1:0]     write address
//   i_wr_data     [CHAR_W-1:0] glyph code written
//   i_msg_len     [AW:0]       active message length, 0..MSG_DEPTH
//   i_step_ovr    [5:0]        0 = STEP_DIV, else period {ovr,4'hF}+1 cycles
//   i_pause       freeze step prescaler and scroll position
//   i_restart     synchronous clear of scroll position and step prescaler
//   i_blink       (SEG7_SCROLL_BLINK_EN only) blink enable
//   o_segments    [6:0]        {g,f,e,d,c,b,a}, active high, registered
//   o_digit_sel   [NUM_DIGITS-1:0] one-hot digit enable, bit0 leftmost
//   o_scroll_pos  [AW-1:0]     glyph index on the leftmost digit
//   o_wrap        one-cycle pulse when the scroll position wraps to 0
// -----------------------------------------------------------------------------
module seg7_scroll_mux
  import seg7_scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH  = 32,
  parameter int CHAR_W     = 5,
  parameter int SCAN_DIV   = 10_000,
  parameter int STEP_DIV   = 10_000_000,
  parameter int CNT_W      = 24,
  localparam int AW = $clog2(MSG_DEPTH),
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ena,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [CHAR_W-1:0]     i_wr_data,
  input  logic [AW:0]           i_msg_len,
  input  logic [5:0]            i_step_ovr,
  input  logic                  i_pause,
  input  logic                  i_restart,
`ifdef SEG7_SCROLL_BLINK_EN
  input  logic                  i_blink,
`endif
  output logic [6:0]            o_segments,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic [AW-1:0]         o_scroll_pos,
  output logic                  o_wrap
);

  logic [CHAR_W-1:0]     r_mem [MSG_DEPTH];
  logic [CNT_W-1:0]      r_stepCnt;
  logic [CNT_W-1:0]      r_scanCnt;
  logic [AW-1:0]         r_pos;
  logic [DW-1:0]         r_digit;
  logic                  r_wrap;
  logic [6:0]            r_segments;
  logic [NUM_DIGITS-1:0] r_digitSel;

  logic [CNT_W-1:0]      w_stepLimit;
  logic                  w_stepTick;
  logic                  w_scanTerm;
  logic [AW:0]           w_posExt;
  logic [AW:0]           w_digitExt;
  logic [AW:0]           w_sum;
  logic [AW-1:0]         w_rdAddr;
  logic [CHAR_W-1:0]     w_rdGlyph;
  logic [CHAR_W-1:0]     w_charCode;
  logic                  w_digitActive;
  logic                  w_posOutOfRange;
  logic                  w_posAtEnd;
  logic [6:0]            w_segDecoded;
  logic [NUM_DIGITS-1:0] w_digitOneHot;
  logic                  w_forceBlank;

  // Message RAM: synchronous write, asynchronous read, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Step period select. The tick uses >= so that shortening the period while
  // the prescaler is already past the new limit ticks at once instead of
  // running round the whole counter range.
  assign w_stepLimit = (i_step_ovr == 6'd0) ? CNT_W'(STEP_DIV - 1)
                                            : CNT_W'({i_step_ovr, 4'hF});
  assign w_stepTick  = (r_stepCnt >= w_stepLimit);
  assign w_scanTerm  = (r_scanCnt >= CNT_W'(SCAN_DIV - 1));

  // Glyph address for the digit being scanned. Both operands are below
  // msg_len in normal operation, so one conditional subtract is the modulo.
  assign w_posExt   = {1'b0, r_pos};
  assign w_digitExt = (AW+1)'(r_digit);
  assign w_sum      = w_posExt + w_digitExt;
  assign w_rdAddr   = AW'((w_sum >= i_msg_len) ? (w_sum - i_msg_len) : w_sum);
  assign w_rdGlyph  = r_mem[w_rdAddr];

  // Digits past the end of a short message show the blank glyph.
  assign w_digitActive = (w_digitExt < i_msg_len);
  assign w_charCode    = w_digitActive ? w_rdGlyph : CHAR_W'(GLYPH_BLANK);

  // A shrunk length can leave the position past the end; msg_len==0 always
  // lands here, which pins the position at 0 with no wrap pulse.
  assign w_posOutOfRange = (i_msg_len <= w_posExt);
  assign w_posAtEnd      = (w_posExt == (i_msg_len - (AW+1)'(1)));

  seg7_glyph #(
    .CHAR_W(CHAR_W)
  ) u_glyph (
    .i_code    (w_charCode),
    .o_segments(w_segDecoded)
  );

  // One-hot digit enable for the digit index currently being scanned.
  always_comb begin
    w_digitOneHot          = '0;
    w_digitOneHot[r_digit] = 1'b1;
  end

  // Step prescaler, scroll position and wrap pulse. Disable holds everything
  // except the wrap pulse, which is dropped so it cannot stretch while frozen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stepCnt <= '0;
      r_pos     <= '0;
      r_wrap    <= 1'b0;
    end else if (!i_ena) begin
      r_wrap <= 1'b0;
    end else if (i_restart) begin
      r_stepCnt <= '0;
      r_pos     <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!i_pause) begin
        r_stepCnt <= w_stepTick ? '0 : r_stepCnt + 1'b1;
      end
      if (w_posOutOfRange) begin
        r_pos <= '0;
      end else if (!i_pause && w_stepTick) begin
        if (w_posAtEnd) begin
          r_pos  <= '0;
          r_wrap <= 1'b1;
        end else begin
          r_pos <= r_pos + 1'b1;
        end
      end
    end
  end

  // Scan prescaler and digit index; the scan keeps running while paused.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scanCnt <= '0;
      r_digit   <= '0;
    end else if (i_ena) begin
      if (w_scanTerm) begin
        r_scanCnt <= '0;
        r_digit   <= (r_digit == DW'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
      end else begin
        r_scanCnt <= r_scanCnt + 1'b1;
      end
    end
  end

`ifdef SEG7_SCROLL_BLINK_EN
  logic r_phase;

  // Blink phase follows the step ticks and restarts dark-free on restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 1'b0;
    end else if (i_ena) begin
      if (i_restart) begin
        r_phase <= 1'b0;
      end else if (!i_pause && w_stepTick) begin
        r_phase <= ~r_phase;
      end
    end
  end

  assign w_forceBlank = i_blink & r_phase;
`else
  assign w_forceBlank = 1'b0;
`endif

  // Segment and digit enables are registered together so they never skew.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_segments <= SEG_BLANK;
      r_digitSel <= '0;
    end else if (!i_ena) begin
      r_segments <= SEG_BLANK;
      r_digitSel <= '0;
    end else begin
      r_segments <= w_forceBlank ? SEG_BLANK : w_segDecoded;
      r_digitSel <= w_digitOneHot;
    end
  end

  assign o_segments   = r_segments;
  assign o_digit_sel  = r_digitSel;
  assign o_scroll_pos = r_pos;
  assign o_wrap       = r_wrap;

endmodule
